// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the flag PIO: register word addresses, edge-type
// selectors and the event counter saturation value.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EVT_CNT  = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam logic [31:0] EVT_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One flag bit: 2-flop synchroniser followed by an optional stability filter.
// filt only follows the synchronised input once it has differed for DEBOUNCE_CYCLES cycles.
module soc_system_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic filt
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in_bit;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt = s2;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          filt_q;

            // Any return to the filtered value restarts the stability count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt    <= '0;
                    filt_q <= 1'b0;
                end else if (s2 == filt_q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    filt_q <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

endmodule

// File: rtl/soc_system_flag_pio.sv
// Avalon-MM input PIO for status flags: synchronised/debounced inputs, W1C edge
// capture, interrupt mask, level irq and a saturating event counter.
module soc_system_flag_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap_clear;
    logic [31:0]      event_count;
    logic [31:0]      read_mux;
    logic             wr_mask;
    logic             wr_cap;
    logic             wr_cnt;
    logic             new_event;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            soc_system_pio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .in_bit(in_port[gi]),
                .filt  (filt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= filt;
        end
    end

    always_comb begin
        edge_vec = '0;
        if (EDGE_TYPE == EDGE_RISING) begin
            edge_vec = filt & ~prev;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_vec = ~filt & prev;
        end else begin
            edge_vec = filt ^ prev;
        end
    end

    // Bus: a strobe is accepted in the cycle it is high (no wait states); a read
    // returns data one cycle later and sees register values from before any
    // write accepted in the same cycle.
    assign wr_mask   = write && (address == ADDR_IRQ_MASK);
    assign wr_cap    = write && (address == ADDR_EDGE_CAP);
    assign wr_cnt    = write && (address == ADDR_EVT_CNT);
    assign cap_clear = wr_cap ? writedata[WIDTH-1:0] : '0;
    assign new_event = |(edge_vec & ~edge_capture);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // A fresh edge overrides a clear on the same bit.
            edge_capture <= (edge_capture & ~cap_clear) | edge_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_count <= '0;
        end else if (wr_cnt) begin
            event_count <= {31'd0, new_event};
        end else if (new_event && (event_count != EVT_CNT_MAX)) begin
            event_count <= event_count + 32'd1;
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:     read_mux[WIDTH-1:0] = filt;
            ADDR_IRQ_MASK: read_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: read_mux[WIDTH-1:0] = edge_capture;
            ADDR_EVT_CNT:  read_mux            = event_count;
            default:       read_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= read_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_flag_pio.sv
// Bench for soc_system_flag_pio: three instances (rising/no debounce,
// rising/debounce 4, any-edge/no debounce), directed tables and sequences,
// then randomized traffic against a sample-history reference model.
module tb_soc_system_flag_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address   [3];
    logic        read      [3];
    logic        write     [3];
    logic [31:0] writedata [3];
    logic [31:0] readdata  [3];
    logic [5:0]  in_port   [3];
    logic        irq       [3];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    soc_system_flag_pio #(.WIDTH(6), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) dut_rise (
        .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
        .writedata(writedata[0]), .readdata(readdata[0]), .in_port(in_port[0]), .irq(irq[0])
    );

    soc_system_flag_pio #(.WIDTH(6), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut_db (
        .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
        .writedata(writedata[1]), .readdata(readdata[1]), .in_port(in_port[1]), .irq(irq[1])
    );

    soc_system_flag_pio #(.WIDTH(6), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) dut_any (
        .clk(clk), .reset(reset), .address(address[2]), .read(read[2]), .write(write[2]),
        .writedata(writedata[2]), .readdata(readdata[2]), .in_port(in_port[2]), .irq(irq[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_irq(input int d, input string name, input logic exp);
        check(name, {31'd0, irq[d]}, {31'd0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input int d, input logic [1:0] a, input logic [31:0] exp, input string name);
        address[d] = a;
        read[d]    = 1'b1;
        @(posedge clk);
        #1;
        read[d] = 1'b0;
        check(name, readdata[d], exp);
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] data);
        address[d]   = a;
        writedata[d] = data;
        write[d]     = 1'b1;
        @(posedge clk);
        #1;
        write[d] = 1'b0;
    endtask

    typedef struct {
        logic        is_write;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [5:0]  in_val;
        int          pre_idle;
    } vec_t;

    vec_t tbl[15];

    // Reference model: filt after edge k equals in_port sampled at edge k-1,
    // so the edge judged at edge k compares the samples taken at k-2 and k-3.
    logic [5:0]  hist[$];
    logic [5:0]  m_cap;
    logic [5:0]  m_mask;
    logic [31:0] m_cnt;
    logic [31:0] m_rd;

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back(6'd0);
        m_cap  = '0;
        m_mask = '0;
        m_cnt  = '0;
        m_rd   = '0;
    endtask

    task automatic model_step(input logic [5:0] in_v, input logic [1:0] a, input logic rd,
                              input logic wr, input logic [31:0] wd);
        int          n;
        logic [5:0]  now_val;
        logic [5:0]  old_val;
        logic [5:0]  rises;
        logic        fresh;
        hist.push_back(in_v);
        n       = hist.size();
        now_val = hist[n-3];
        old_val = hist[n-4];
        rises   = now_val & ~old_val;
        fresh   = (rises & ~m_cap) != 6'd0;
        if (rd) begin
            case (a)
                2'd0:    m_rd = {26'd0, now_val};
                2'd1:    m_rd = {26'd0, m_mask};
                2'd2:    m_rd = {26'd0, m_cap};
                default: m_rd = m_cnt;
            endcase
        end
        if (wr && a == 2'd2) m_cap = m_cap & ~wd[5:0];
        m_cap = m_cap | rises;
        if (wr && a == 2'd1) m_mask = wd[5:0];
        if (wr && a == 2'd3)            m_cnt = fresh ? 32'd1 : 32'd0;
        else if (fresh && m_cnt != '1)  m_cnt = m_cnt + 32'd1;
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  in_v;
        logic [1:0]  a;
        logic        rd;
        logic        wr;
        logic [31:0] wd;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address[i]   = '0;
            read[i]      = 1'b0;
            write[i]     = 1'b0;
            writedata[i] = '0;
            in_port[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values, read-only DATA, unused bits, W1C and counter clear.
        tbl[0]  = '{1'b0, 2'd0, 32'h0,         6'h00, 0};
        tbl[1]  = '{1'b0, 2'd1, 32'h0,         6'h00, 0};
        tbl[2]  = '{1'b0, 2'd2, 32'h0,         6'h00, 0};
        tbl[3]  = '{1'b0, 2'd3, 32'h0,         6'h00, 0};
        tbl[4]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 6'h00, 0};
        tbl[5]  = '{1'b0, 2'd0, 32'h0,         6'h00, 0};
        tbl[6]  = '{1'b0, 2'd0, 32'h0000_002A, 6'h2A, 3};
        tbl[7]  = '{1'b0, 2'd2, 32'h0000_002A, 6'h2A, 0};
        tbl[8]  = '{1'b0, 2'd3, 32'h1,         6'h2A, 0};
        tbl[9]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 6'h2A, 0};
        tbl[10] = '{1'b0, 2'd2, 32'h0,         6'h2A, 0};
        tbl[11] = '{1'b1, 2'd3, 32'h0000_1234, 6'h2A, 0};
        tbl[12] = '{1'b0, 2'd3, 32'h0,         6'h2A, 0};
        tbl[13] = '{1'b0, 2'd2, 32'h0,         6'h00, 4};
        tbl[14] = '{1'b0, 2'd3, 32'h0,         6'h00, 0};
        for (int i = 0; i < 15; i++) begin
            in_port[0] = tbl[i].in_val;
            idle(tbl[i].pre_idle);
            if (tbl[i].is_write) bus_write(0, tbl[i].addr, tbl[i].data);
            else bus_read(0, tbl[i].addr, tbl[i].data, $sformatf("tbl[%0d]", i));
        end

        // Rising edge on bit3 lands in EDGE_CAPTURE after the third edge.
        in_port[0] = 6'h08;
        bus_read(0, 2'd2, 32'h0, "cap_lat_e1");
        bus_read(0, 2'd2, 32'h0, "cap_lat_e2");
        bus_read(0, 2'd2, 32'h0, "cap_lat_e3");
        bus_read(0, 2'd2, 32'h8, "cap_lat_e4");
        bus_read(0, 2'd3, 32'h1, "cnt_after_rise");
        in_port[0] = 6'h00;
        idle(4);
        bus_read(0, 2'd2, 32'h8, "fall_ignored");
        bus_write(0, 2'd2, 32'h8);
        bus_read(0, 2'd2, 32'h0, "w1c_clear");

        // Masking: captured but masked bit keeps irq low until unmasked.
        bus_write(0, 2'd1, 32'h1);
        in_port[0] = 6'h08;
        idle(4);
        check_irq(0, "irq_masked", 1'b0);
        bus_write(0, 2'd1, 32'h9);
        check_irq(0, "irq_unmask", 1'b1);
        bus_write(0, 2'd2, 32'h8);
        check_irq(0, "irq_w1c_drop", 1'b0);

        // New edge on bit0 coinciding with its W1C keeps the bit set.
        in_port[0] = 6'h09;
        idle(4);
        check_irq(0, "irq_bit0", 1'b1);
        in_port[0] = 6'h08;
        idle(4);
        in_port[0] = 6'h09;
        idle(2);
        bus_write(0, 2'd2, 32'h1);
        check_irq(0, "irq_set_wins", 1'b1);
        bus_read(0, 2'd2, 32'h1, "cap_set_wins");
        bus_read(0, 2'd3, 32'h3, "cnt_no_repeat");
        bus_write(0, 2'd2, 32'h1);
        check_irq(0, "irq_clear_b0", 1'b0);

        // Debounce: a 3-cycle glitch is filtered, a held level passes after 2+4.
        bus_write(1, 2'd1, 32'h2);
        in_port[1] = 6'h02;
        idle(3);
        in_port[1] = 6'h00;
        idle(10);
        bus_read(1, 2'd0, 32'h0, "db_glitch_data");
        bus_read(1, 2'd2, 32'h0, "db_glitch_cap");
        in_port[1] = 6'h02;
        for (int k = 1; k <= 7; k++) begin
            bus_read(1, 2'd0, (k == 7) ? 32'h2 : 32'h0, $sformatf("db_data_e%0d", k));
            check_irq(1, $sformatf("db_irq_e%0d", k), k == 7);
        end
        bus_read(1, 2'd2, 32'h2, "db_cap");
        idle(3);

        // Any-edge counting with W1C between toggles, then counter clear.
        for (int t = 0; t < 5; t++) begin
            in_port[2] = in_port[2] ^ 6'h01;
            idle(3);
            bus_read(2, 2'd2, 32'h1, $sformatf("any_cap_t%0d", t));
            bus_write(2, 2'd2, 32'h1);
        end
        bus_read(2, 2'd3, 32'h5, "any_cnt5");
        bus_write(2, 2'd3, 32'h0);
        bus_read(2, 2'd3, 32'h0, "any_cnt_clr");

        // Reset mid-debounce: irq drops without waiting for a clock edge.
        in_port[1] = 6'h00;
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        check_irq(1, "rst_irq_async", 1'b0);
        for (int i = 0; i < 3; i++) in_port[i] = '0;
        idle(2);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus_read(1, 2'(r), 32'h0, $sformatf("rst_reg%0d", r));
        end
        idle(4);
        bus_read(1, 2'd2, 32'h0, "rst_no_edge");

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < 2; c++) model_step(6'd0, 2'd0, 1'b0, 1'b0, 32'd0);
        for (int c = 0; c < 1500; c++) begin
            in_v = ($urandom_range(0, 3) == 0) ? 6'($urandom) : in_port[0];
            a    = 2'($urandom_range(0, 3));
            rd   = 1'($urandom_range(0, 1));
            wr   = ($urandom_range(0, 3) == 0);
            wd   = $urandom;
            in_port[0]   = in_v;
            address[0]   = a;
            read[0]      = rd;
            write[0]     = wr;
            writedata[0] = wd;
            @(posedge clk);
            model_step(in_v, a, rd, wr, wd);
            #1;
            read[0]  = 1'b0;
            write[0] = 1'b0;
            check($sformatf("rand_rd_c%0d", c), readdata[0], m_rd);
            check_irq(0, $sformatf("rand_irq_c%0d", c), (m_cap & m_mask) != 6'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/soc_system_flag_pio.md
Name: soc_system_flag_pio

Overview:
Parametrised Avalon-MM input PIO for status/flag lines from the LVDS capture and SRAM logic to the HPS. It extends the plain read-only flag port with several features:
- a 2-flop input synchroniser;
- an optional per-bit debounce filter;
- per-bit edge capture, cleared by writing 1 to the bit (W1C);
- an interrupt mask and interrupt output;
- a saturating event counter.

Parameters:
WIDTH, 6, number of input flag bits (1..32).
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the filtered value changes; 0 bypasses the filter.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
address  in  2  register word address.
read  in  1  Avalon read strobe.
write  in  1  Avalon write strobe.
writedata  in  32  write data.
readdata  out  32  registered read data.
in_port  in  WIDTH  asynchronous flag inputs.
irq  out  1  level interrupt to the HPS.

Behaviour:
- Reset: every flop clears to 0. This covers readdata, irq, s1, s2, filt, prev, the debounce counters, irq_mask, edge_capture and event_count.
- Synchroniser: s1 <= in_port; s2 <= s1. There is no reset-bypass path.
- Filter, DEBOUNCE_CYCLES=0: filt = s2 (wire).
- Filter, DEBOUNCE_CYCLES>0, per bit:
  - s2==filt: cnt <= 0.
  - s2!=filt and cnt==DEBOUNCE_CYCLES-1: filt <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches filt.
- Edge detect: prev <= filt. The edge vector is:
  - EDGE_TYPE 0: filt & ~prev.
  - EDGE_TYPE 1: ~filt & prev.
  - EDGE_TYPE 2: filt ^ prev.
- Latency with no debounce: in_port is stable before rising edge 1.
  - filt is visible after edge 2.
  - The edge_capture bit is set after edge 3.
  - The debounce filter adds DEBOUNCE_CYCLES cycles.
- Register map:
  - 0 DATA: RO, filt zero-extended; writes are ignored.
  - 1 IRQ_MASK: RW, bits [WIDTH-1:0].
  - 2 EDGE_CAPTURE: RW1C. edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | edge. A new edge on the same bit in the same cycle as its clear wins, so the bit stays set.
  - 3 EVENT_COUNT: RO count. It increments by 1 in each cycle where |(edge & ~edge_capture) is true, i.e. at least one bit newly sets. It saturates at 32'hFFFF_FFFF. Any write clears it. If a write and an event occur in the same cycle, the result is 1.
- Unused bits [31:WIDTH]: read as 0; write data is ignored.
- Read: readdata <= mux(address) when read=1; otherwise readdata holds its value. Read latency is 1 cycle with no wait states. A read of EDGE_CAPTURE has no side effect. A read and a write in the same cycle return the pre-write value.
- irq: irq = |(edge_capture & irq_mask), ORed from registered values with no extra flop.
  - It deasserts the cycle after the W1C write that clears the last enabled bit, unless a new edge lands on that bit.
  - Unmasking an already-captured bit asserts irq in the next cycle.
- Reset release with an input held high: the synchroniser then produces a 0->1 edge, which is captured for EDGE_TYPE 0/2. This is intentional. Software clears EDGE_CAPTURE during init; irq cannot fire because irq_mask=0.
- Reset mid-operation: all state clears immediately, including the debounce counters; any partial filter count is discarded.

Decomposition:
- Package soc_system_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQ_MASK=1, ADDR_EDGE_CAP=2, ADDR_EVT_CNT=3;
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2;
  - the counter saturation constant.
- Sub-module soc_system_pio_debounce: one bit of synchroniser plus filter, parameter DEBOUNCE_CYCLES, output filt. It is instantiated WIDTH times in a generate loop. Edge logic, registers and the Avalon interface stay in the top module.

Test Plan:
1. Reset / unused bits: after reset, read all 4 addresses -> 0. Write 32'hFFFF_FFFF to DATA, then read DATA -> 0. With in_port=6'h2A, DATA reads 32'h0000_002A and bits [31:6] are 0.
2. Rising-edge capture (EDGE_TYPE 0):
   - Set in_port bit3 0->1 -> EDGE_CAPTURE=0x08 exactly 3 clk later and EVENT_COUNT=1.
   - Set bit3 1->0 -> no change.
   - Write 0x08 to EDGE_CAPTURE -> reads 0x00.
3. IRQ masking:
   - IRQ_MASK=0x01 with a bit3 edge -> irq stays 0.
   - Write IRQ_MASK=0x09 -> irq=1 next cycle.
   - W1C 0x08 -> irq=0 next cycle.
4. Simultaneous set/clear: time a bit0 edge to land in the cycle of a W1C 0x01 -> EDGE_CAPTURE bit0 remains 1, and irq stays 1 if bit0 is unmasked.
5. Debounce (DEBOUNCE_CYCLES=4):
   - Pulse in_port bit1 for 3 cycles -> DATA and EDGE_CAPTURE unchanged.
   - Hold bit1 high for 10 cycles -> DATA bit1=1 at 2+4 cycles, capture at 7 cycles.
6. EVENT_COUNT and reset:
   - EDGE_TYPE 2: toggle bit0 five times with a W1C between toggles -> EVENT_COUNT=5.
   - A write to EVENT_COUNT clears it to 0.
   - Asserting reset mid-debounce clears all registers, and irq drops asynchronously.
